alu_vec_pipe: RTL

//  Parametrised, handshaked successor of the 16x16-bit vector ALU in the vector datapath.
//  - Computes LANES independent LANE_W-bit ops, with per-lane N/Z/C/V flags.
//  - Adds a result register, valid/ready flow control, a per-lane write mask and a multi-cycle MUL.
//  - Sits between vector operand read and the vector writeback stage.

---
 rtl/alu_vec_pkg.sv | 27 ++
 rtl/alu_vec_lane.sv | 88 ++++++++
 rtl/alu_vec_pipe.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_vec_pkg.sv
// Shared types for the vector ALU: opcodes, flag bit positions and FSM states.
package alu_vec_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } opcode_e;

  // Bit positions inside each lane's 4-bit flag nibble {N,Z,C,V}.
  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_vec_lane.sv
// Single-lane combinational ALU op with N/Z/C/V flags.
//   a_i, b_i  : lane operands
//   op_i      : operation select
//   en_i      : 1 = compute, 0 = pass a_i through with zero flags
//   res_o     : lane result (modulo 2^LANE_W)
//   flags_o   : {N,Z,C,V}
module alu_vec_lane
  import alu_vec_pkg::*;
#(
  parameter int unsigned LANE_W = 16
) (
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  input  opcode_e           op_i,
  input  logic              en_i,
  output logic [LANE_W-1:0] res_o,
  output logic [3:0]        flags_o
);

  localparam int unsigned SH_W = $clog2(LANE_W);

  logic [SH_W-1:0]     amt;
  logic [LANE_W:0]     sum;
  logic [LANE_W:0]     diff;
  logic [LANE_W:0]     shl_w;
  logic [LANE_W:0]     shr_w;
  logic [2*LANE_W-1:0] prod;
  logic [LANE_W-1:0]   res;
  logic                c;
  logic                v;

  assign amt  = b_i[SH_W-1:0];
  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign diff = {1'b0, a_i} - {1'b0, b_i};
  // One guard bit on each side catches the last bit shifted out (0 for a zero shift).
  assign shl_w = {1'b0, a_i} << amt;
  assign shr_w = {a_i, 1'b0} >> amt;
  assign prod  = {{LANE_W{1'b0}}, a_i} * {{LANE_W{1'b0}}, b_i};

  // Operation select and flag generation.
  always_comb begin
    res     = '0;
    c       = 1'b0;
    v       = 1'b0;
    res_o   = '0;
    flags_o = '0;
    case (op_i)
      OP_ADD: begin
        res = sum[LANE_W-1:0];
        c   = sum[LANE_W];
        v   = ~(a_i[LANE_W-1] ^ b_i[LANE_W-1]) & (res[LANE_W-1] ^ a_i[LANE_W-1]);
      end
      OP_SUB: begin
        res = diff[LANE_W-1:0];
        c   = diff[LANE_W];
        v   = (a_i[LANE_W-1] ^ b_i[LANE_W-1]) & (res[LANE_W-1] ^ a_i[LANE_W-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
      OP_SHL: begin
        res = shl_w[LANE_W-1:0];
        c   = shl_w[LANE_W];
      end
      OP_SHR: begin
        res = shr_w[LANE_W:1];
        c   = shr_w[0];
      end
      OP_MUL: begin
        res = prod[LANE_W-1:0];
        c   = |prod[2*LANE_W-1:LANE_W];
        v   = |prod[2*LANE_W-1:LANE_W];
      end
      default: res = '0;
    endcase

    if (en_i) begin
      res_o           = res;
      flags_o[FLAG_N] = res[LANE_W-1];
      flags_o[FLAG_Z] = (res == '0);
      flags_o[FLAG_C] = c;
      flags_o[FLAG_V] = v;
    end else begin
      res_o = a_i;
    end
  end

endmodule

// File: rtl/alu_vec_pipe.sv
// Handshaked vector ALU: LANES independent LANE_W-bit lanes, registered result,
// per-lane write mask, scalar broadcast of b lane 0 and a multi-cycle MUL.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (in_ready is combinational in OUT)
//   a, b, opcode        : packed lane operands and operation
//   flag_scalar         : broadcast b lane 0 to all lanes
//   lane_mask           : 1 = lane computes, 0 = lane passes a with zero flags
//   out_valid/out_ready : result handshake
//   result, flags       : lane results and {N,Z,C,V} per lane
module alu_vec_pipe
  import alu_vec_pkg::*;
#(
  parameter int unsigned LANES   = 16,
  parameter int unsigned LANE_W  = 16,
  parameter int unsigned MUL_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] a,
  input  logic [LANES*LANE_W-1:0] b,
  input  logic [2:0]              opcode,
  input  logic                    flag_scalar,
  input  logic [LANES-1:0]        lane_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] result,
  output logic [4*LANES-1:0]      flags
);

  localparam int unsigned VEC_W    = LANES * LANE_W;
  localparam int unsigned CNT_W    = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned CNT_INIT = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam bit          LONG_MUL = (MUL_LAT > 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [VEC_W-1:0]     a_q, b_q;
  opcode_e              op_q;
  logic [LANES-1:0]     mask_q;
  logic [VEC_W-1:0]     result_q;
  logic [4*LANES-1:0]   flags_q;

  logic [VEC_W-1:0]     b_bcast;
  logic                 accept;
  logic                 go_mul;
  logic                 hold;
  logic                 mul_done;
  logic                 load_res;
  logic [VEC_W-1:0]     lane_a, lane_b;
  opcode_e              lane_op;
  logic [LANES-1:0]     lane_en;
  logic [VEC_W-1:0]     lane_res;
  logic [4*LANES-1:0]   lane_flags;

  assign b_bcast  = flag_scalar ? {LANES{b[LANE_W-1:0]}} : b;
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_OUT) & out_ready);
  assign accept   = in_valid & in_ready;
  assign go_mul   = LONG_MUL && (opcode_e'(opcode) == OP_MUL);
  assign hold     = (state_q == S_MUL);
  assign mul_done = hold && (cnt_q == CNT_W'(0));
  // Single-cycle ops load straight from the live inputs; MUL loads from the held copy.
  assign load_res = (accept & ~go_mul) | mul_done;

  assign lane_a  = hold ? a_q    : a;
  assign lane_b  = hold ? b_q    : b_bcast;
  assign lane_op = hold ? op_q   : opcode_e'(opcode);
  assign lane_en = hold ? mask_q : lane_mask;

  // Lane datapath replicated LANES times.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    alu_vec_lane #(
      .LANE_W(LANE_W)
    ) u_lane (
      .a_i    (lane_a[i*LANE_W +: LANE_W]),
      .b_i    (lane_b[i*LANE_W +: LANE_W]),
      .op_i   (lane_op),
      .en_i   (lane_en[i]),
      .res_o  (lane_res[i*LANE_W +: LANE_W]),
      .flags_o(lane_flags[4*i +: 4])
    );
  end

  // Next-state and MUL countdown.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = go_mul ? S_MUL : S_OUT;
      if (go_mul) cnt_d = CNT_W'(CNT_INIT);
    end else begin
      case (state_q)
        S_MUL: begin
          if (mul_done) state_d = S_OUT;
          else          cnt_d   = cnt_q - CNT_W'(1);
        end
        S_OUT:   if (out_ready) state_d = S_IDLE;
        S_IDLE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, operand capture and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q    <= a;
        b_q    <= b_bcast;
        op_q   <= opcode_e'(opcode);
        mask_q <= lane_mask;
      end
      if (load_res) begin
        result_q <= lane_res;
        flags_q  <= lane_flags;
      end
    end
  end

  assign out_valid = (state_q == S_OUT);
  assign result    = result_q;
  assign flags     = flags_q;

endmodule
